// File: rtl/bnn_class_voter.sv
// Vote accumulator / argmax output stage for the BNN datapath: counts per-class votes over WINDOW samples
// and hands the winning class out through valid/ready. Optional BNN_VOTER_MARGIN_EN adds the out_margin port.
module bnn_class_voter #(
  parameter int NUM_CLASSES = 4,
  parameter int WINDOW      = 8,
  parameter int CNT_W       = $clog2(WINDOW + 1),
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [NUM_CLASSES-1:0] in_bits,
  output logic                   in_ready,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_class,
  output logic [CNT_W-1:0]       out_votes,
  output logic                   out_tie,
  output logic                   busy
`ifdef BNN_VOTER_MARGIN_EN
  ,
  output logic [CNT_W-1:0]       out_margin
`endif
);

  typedef enum logic [1:0] {ACCUM, DONE, RESULT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vote_q [NUM_CLASSES];
  logic [CNT_W-1:0] vote_d [NUM_CLASSES];
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] class_q, class_d;
  logic [CNT_W-1:0] votes_q, votes_d;
  logic             tie_q, tie_d;

  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             best_tie;

  // Strict '>' keeps the lowest index on equal counts.
  always_comb begin
    best_idx = '0;
    best_cnt = vote_q[0];
    for (int unsigned k = 1; k < NUM_CLASSES; k++) begin
      if (vote_q[k] > best_cnt) begin
        best_cnt = vote_q[k];
        best_idx = IDX_W'(k);
      end
    end
    best_tie = 1'b0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if ((IDX_W'(k) != best_idx) && (vote_q[k] == best_cnt)) best_tie = 1'b1;
    end
  end

`ifdef BNN_VOTER_MARGIN_EN
  logic [CNT_W-1:0] second_cnt;
  logic [CNT_W-1:0] margin_q, margin_d;

  // Runner-up excludes only the winner, so a tie yields a zero margin.
  always_comb begin
    second_cnt = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if ((IDX_W'(k) != best_idx) && (vote_q[k] > second_cnt)) second_cnt = vote_q[k];
    end
  end

  assign out_margin = margin_q;
`endif

  always_comb begin
    state_d  = state_q;
    vote_d   = vote_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    class_d  = class_q;
    votes_d  = votes_q;
    tie_d    = tie_q;
`ifdef BNN_VOTER_MARGIN_EN
    margin_d = margin_q;
`endif
    if (clear) begin
      state_d  = ACCUM;
      vote_d   = '{default: '0};
      sample_d = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
              vote_d[k] = vote_q[k] + CNT_W'(in_bits[k]);
            end
            sample_d = sample_q + 1'b1;
            if (sample_q == CNT_W'(WINDOW - 1)) state_d = DONE;
          end
        end
        DONE: begin
          class_d = best_idx;
          votes_d = best_cnt;
          tie_d   = best_tie;
`ifdef BNN_VOTER_MARGIN_EN
          margin_d = best_tie ? '0 : best_cnt - second_cnt;
`endif
          valid_d = 1'b1;
          state_d = RESULT;
        end
        RESULT: begin
          if (out_ready) begin
            valid_d  = 1'b0;
            vote_d   = '{default: '0};
            sample_d = '0;
            state_d  = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ACCUM;
      vote_q   <= '{default: '0};
      sample_q <= '0;
      valid_q  <= 1'b0;
      class_q  <= '0;
      votes_q  <= '0;
      tie_q    <= 1'b0;
`ifdef BNN_VOTER_MARGIN_EN
      margin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vote_q   <= vote_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      class_q  <= class_d;
      votes_q  <= votes_d;
      tie_q    <= tie_d;
`ifdef BNN_VOTER_MARGIN_EN
      margin_q <= margin_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = valid_q;
  assign out_class = class_q;
  assign out_votes = votes_q;
  assign out_tie   = tie_q;
  assign busy      = (sample_q != '0) | (state_q != ACCUM);

endmodule

// File: tb/tb_bnn_class_voter.sv
// Directed + randomized bench for bnn_class_voter (WINDOW=4); results compared against a
// count-and-sort reference model of the voting rules.
module tb_bnn_class_voter;
  localparam int NC = 4;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(NC);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [NC-1:0] in_bits;
  logic          in_ready;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [CW-1:0] out_votes;
  logic          out_tie;
  logic          busy;
`ifdef BNN_VOTER_MARGIN_EN
  logic [CW-1:0] out_margin;
`endif

  bnn_class_voter #(
    .NUM_CLASSES(NC),
    .WINDOW     (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bits  (in_bits),
    .in_ready (in_ready),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_votes(out_votes),
    .out_tie  (out_tie),
    .busy     (busy)
`ifdef BNN_VOTER_MARGIN_EN
    ,
    .out_margin(out_margin)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [NC-1:0] win_q[$];
  int exp_class, exp_votes, exp_tie, exp_margin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: total votes per class, then rank the totals with a sort.
  task automatic model();
    int cnt[NC];
    int q[$];
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    foreach (win_q[i])
      for (int k = 0; k < NC; k++) cnt[k] += int'(win_q[i][k]);
    q = {};
    for (int k = 0; k < NC; k++) q.push_back(cnt[k]);
    q.rsort();
    exp_votes = q[0];
    exp_class = -1;
    for (int k = NC - 1; k >= 0; k--) if (cnt[k] == q[0]) exp_class = k;
    exp_tie    = (NC > 1 && q[1] == q[0]) ? 1 : 0;
    exp_margin = exp_tie ? 0 : q[0] - q[1];
  endtask

  task automatic check_result(input string tag);
    model();
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_class"}, 32'(out_class), exp_class);
    check({tag, "_votes"}, 32'(out_votes), exp_votes);
    check({tag, "_tie"},   32'(out_tie),   exp_tie);
`ifdef BNN_VOTER_MARGIN_EN
    check({tag, "_margin"}, 32'(out_margin), exp_margin);
`endif
  endtask

  // Feeds win_q with optional idle gaps, then checks the one-cycle decision latency.
  task automatic feed_window(input string tag, input int max_gap);
    int gap;
    foreach (win_q[i]) begin
      gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_bits  = NC'($urandom);
        tick();
        check({tag, "_gap_novalid"}, 32'(out_valid), 0);
      end
      in_valid = 1'b1;
      in_bits  = win_q[i];
      check({tag, "_acc_ready"}, 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
    end
    check({tag, "_done_novalid"}, 32'(out_valid), 0);
    check({tag, "_done_ready"},   32'(in_ready), 0);
    tick();
    check_result(tag);
  endtask

  task automatic drain(input string tag, input int delay);
    logic [31:0] c, v, t;
    c = 32'(out_class);
    v = 32'(out_votes);
    t = 32'(out_tie);
    out_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      in_valid = 1'b1;
      in_bits  = NC'($urandom);
      tick();
      check({tag, "_bp_ready"}, 32'(in_ready), 0);
      check({tag, "_bp_valid"}, 32'(out_valid), 1);
      check({tag, "_bp_class"}, 32'(out_class), c);
      check({tag, "_bp_votes"}, 32'(out_votes), v);
      check({tag, "_bp_tie"},   32'(out_tie), t);
    end
    in_valid  = 1'b1;
    in_bits   = NC'($urandom);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid), 0);
    check({tag, "_hs_ready"}, 32'(in_ready), 1);
    check({tag, "_hs_busy"},  32'(busy), 0);
    check({tag, "_hs_class"}, 32'(out_class), c);
    check({tag, "_hs_votes"}, 32'(out_votes), v);
  endtask

  initial begin
    logic [6:0] pat;
    int         nvalid;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bits   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_class", 32'(out_class), 0);
    check("rst_votes", 32'(out_votes), 0);
    check("rst_tie",   32'(out_tie), 0);
    reset = 1'b0;
    tick();

    // Basic window
    win_q = {4'b0001, 4'b0011, 4'b0001, 4'b0101};
    feed_window("basic", 0);
    check("basic_busy", 32'(busy), 1);
    drain("basic", 0);

    // Tie resolves to the lowest index
    win_q = {4'b0110, 4'b0110, 4'b0000, 4'b0000};
    feed_window("tie", 0);
    drain("tie", 5);

    // Fresh window after backpressure; in_valid gaps 1,0,0,1,1,0,1
    win_q  = {4'b1000, 4'b1000, 4'b1000, 4'b1000};
    pat    = 7'b1011001;
    nvalid = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_bits  = 4'b1000;
      tick();
      if (pat[i]) nvalid++;
      if (nvalid < W) check("gaps_early", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    check("gaps_done", 32'(out_valid), 0);
    tick();
    check_result("gaps");
    drain("gaps", 1);

    // Clear alongside the 4th sample drops the window
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bits  = 4'b0010;
      tick();
    end
    check("clr_busy_pre", 32'(busy), 1);
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_busy",  32'(busy), 0);
    check("clr_ready", 32'(in_ready), 1);
    tick();
    check("clr_novalid", 32'(out_valid), 0);
    win_q = {4'b0100, 4'b0100, 4'b0100, 4'b0100};
    feed_window("postclr", 0);

    // Clear beats a handshake in RESULT
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    check("clr_res_valid", 32'(out_valid), 0);
    check("clr_res_ready", 32'(in_ready), 1);
    check("clr_res_busy",  32'(busy), 0);

    // Async reset while in RESULT
    win_q = {4'b1001, 4'b0011, 4'b1010, 4'b1111};
    feed_window("prerst", 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(in_ready), 1);
    check("arst_busy",  32'(busy), 0);
    check("arst_class", 32'(out_class), 0);
    tick();
    reset = 1'b0;
    tick();
    win_q = {4'b0000, 4'b0000, 4'b0000, 4'b0000};
    feed_window("zero", 0);
    drain("zero", 0);

    // Randomized windows with gaps and backpressure
    for (int r = 0; r < 25; r++) begin
      win_q = {};
      for (int i = 0; i < W; i++) win_q.push_back(NC'($urandom));
      feed_window("rand", 2);
      drain("rand", int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
